// File: rtl/uvmt_axil_st_pkg.sv
// Shared types and constants for the AXI-Lite register slice.
// Payload layouts are {sideband, main field}, matching the packing used by the slice.
package uvmt_axil_st_pkg;

  localparam int unsigned DEF_ADDR_WIDTH      = 32;
  localparam int unsigned DEF_DATA_WIDTH      = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING = 4;
  localparam int unsigned PROT_W              = 3;
  localparam int unsigned RESP_W              = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [PROT_W-1:0]         prot;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } axil_ax_t;

  typedef struct packed {
    logic [DEF_DATA_WIDTH/8-1:0] strb;
    logic [DEF_DATA_WIDTH-1:0]   data;
  } axil_w_t;

  typedef struct packed {
    logic [RESP_W-1:0] resp;
  } axil_b_t;

  typedef struct packed {
    logic [RESP_W-1:0]         resp;
    logic [DEF_DATA_WIDTH-1:0] data;
  } axil_r_t;

  function automatic int unsigned ax_width(input int unsigned addr_w);
    return addr_w + PROT_W;
  endfunction

  function automatic int unsigned w_width(input int unsigned data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int unsigned r_width(input int unsigned data_w);
    return data_w + RESP_W;
  endfunction

endpackage

// File: rtl/uvma_axil_if.sv
// AXI-Lite signal bundle; master drives AW/W/AR and B/R ready, slave the rest.
interface uvma_axil_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, input awready,
    output wvalid, wdata, wstrb, input wready,
    input bvalid, bresp, output bready,
    output arvalid, araddr, arprot, input arready,
    input rvalid, rdata, rresp, output rready
  );

  modport slave (
    input awvalid, awaddr, awprot, output awready,
    input wvalid, wdata, wstrb, output wready,
    output bvalid, bresp, input bready,
    input arvalid, araddr, arprot, output arready,
    output rvalid, rdata, rresp, input rready
  );

endinterface

// File: rtl/uvmt_axil_st_skid_buf.sv
// Two-entry skid buffer: registered input ready, one-cycle latency, one transfer per cycle.
module uvmt_axil_st_skid_buf
  import uvmt_axil_st_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // state | meaning
  // EMPTY | nothing held
  // ONE   | head_q holds the only entry
  // FULL  | head_q oldest, skid_q newer; input stalled

  buf_state_e       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             push, pop;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    skid_q <= skid_d;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    push    = in_valid && in_ready_q;
    pop     = (state_q != EMPTY) && out_ready;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_data;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // ready registered from next state so it never sees out_ready combinationally
    in_ready_d = (state_d != FULL);
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    out_data  = head_q;
    in_ready  = in_ready_q;
  end

endmodule

// File: rtl/uvmt_axil_st_reg_slice.sv
// AXI-Lite register slice: an independent skid buffer on each of AW, W, AR, B and R.
// Define UVMT_AXIL_ST_REG_SLICE_OUTSTANDING_LIMIT_EN to cap outstanding writes/reads.
module uvmt_axil_st_reg_slice
  import uvmt_axil_st_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
  input logic        clk,
  input logic        reset_n,
  uvma_axil_if.slave  mstr_if,
  uvma_axil_if.master slv_if
);

  localparam int unsigned AX_W = ax_width(ADDR_WIDTH);
  localparam int unsigned W_W  = w_width(DATA_WIDTH);
  localparam int unsigned B_W  = RESP_W;
  localparam int unsigned R_W  = r_width(DATA_WIDTH);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 255) begin : g_bad_max_outstanding
    $error("MAX_OUTSTANDING must be in 1..255");
  end

  logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]  w_in, w_out;
  logic [B_W-1:0]  b_in, b_out;
  logic [R_W-1:0]  r_in, r_out;
  logic            aw_buf_ready, ar_buf_ready;
  logic            aw_ok, ar_ok;

`ifdef UVMT_AXIL_ST_REG_SLICE_OUTSTANDING_LIMIT_EN
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
  logic             aw_hs, b_hs, ar_hs, r_hs;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  always_comb begin
    aw_ok    = (wr_cnt_q != CNT_W'(MAX_OUTSTANDING));
    ar_ok    = (rd_cnt_q != CNT_W'(MAX_OUTSTANDING));
    aw_hs    = mstr_if.awvalid && mstr_if.awready;
    b_hs     = mstr_if.bvalid && mstr_if.bready;
    ar_hs    = mstr_if.arvalid && mstr_if.arready;
    r_hs     = mstr_if.rvalid && mstr_if.rready;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    // a response with nothing outstanding is ignored rather than wrapping the count
    if (aw_hs && !b_hs)                       wr_cnt_d = wr_cnt_q + CNT_W'(1);
    else if (b_hs && !aw_hs && wr_cnt_q != 0) wr_cnt_d = wr_cnt_q - CNT_W'(1);
    if (ar_hs && !r_hs)                       rd_cnt_d = rd_cnt_q + CNT_W'(1);
    else if (r_hs && !ar_hs && rd_cnt_q != 0) rd_cnt_d = rd_cnt_q - CNT_W'(1);
  end
`else
  assign aw_ok = 1'b1;
  assign ar_ok = 1'b1;
`endif

  assign aw_in = {mstr_if.awprot, mstr_if.awaddr};
  assign w_in  = {mstr_if.wstrb, mstr_if.wdata};
  assign ar_in = {mstr_if.arprot, mstr_if.araddr};
  assign b_in  = slv_if.bresp;
  assign r_in  = {slv_if.rresp, slv_if.rdata};

  assign {slv_if.awprot, slv_if.awaddr} = aw_out;
  assign {slv_if.wstrb, slv_if.wdata}   = w_out;
  assign {slv_if.arprot, slv_if.araddr} = ar_out;
  assign mstr_if.bresp                  = b_out;
  assign {mstr_if.rresp, mstr_if.rdata} = r_out;

  assign mstr_if.awready = aw_buf_ready && aw_ok;
  assign mstr_if.arready = ar_buf_ready && ar_ok;

  uvmt_axil_st_skid_buf #(.WIDTH(AX_W)) u_aw_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (mstr_if.awvalid && aw_ok),
    .in_ready (aw_buf_ready),
    .in_data  (aw_in),
    .out_valid(slv_if.awvalid),
    .out_ready(slv_if.awready),
    .out_data (aw_out)
  );

  uvmt_axil_st_skid_buf #(.WIDTH(W_W)) u_w_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (mstr_if.wvalid),
    .in_ready (mstr_if.wready),
    .in_data  (w_in),
    .out_valid(slv_if.wvalid),
    .out_ready(slv_if.wready),
    .out_data (w_out)
  );

  uvmt_axil_st_skid_buf #(.WIDTH(AX_W)) u_ar_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (mstr_if.arvalid && ar_ok),
    .in_ready (ar_buf_ready),
    .in_data  (ar_in),
    .out_valid(slv_if.arvalid),
    .out_ready(slv_if.arready),
    .out_data (ar_out)
  );

  uvmt_axil_st_skid_buf #(.WIDTH(B_W)) u_b_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (slv_if.bvalid),
    .in_ready (slv_if.bready),
    .in_data  (b_in),
    .out_valid(mstr_if.bvalid),
    .out_ready(mstr_if.bready),
    .out_data (b_out)
  );

  uvmt_axil_st_skid_buf #(.WIDTH(R_W)) u_r_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (slv_if.rvalid),
    .in_ready (slv_if.rready),
    .in_data  (r_in),
    .out_valid(mstr_if.rvalid),
    .out_ready(mstr_if.rready),
    .out_data (r_out)
  );

endmodule

// File: tb/tb_uvmt_axil_st_reg_slice.sv
// Bench for uvmt_axil_st_reg_slice: per-channel stimulus queues, a 2-deep FIFO
// reference per channel, and a negedge monitor comparing every cycle.
module tb_uvmt_axil_st_reg_slice;

  localparam int NCH  = 5;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uvma_axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();
  uvma_axil_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

  uvmt_axil_st_reg_slice #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .mstr_if(m_if), .slv_if(s_if)
  );

  // channel index: 0 AW, 1 W, 2 AR, 3 B, 4 R
  string cname [NCH] = '{"aw", "w", "ar", "b", "r"};
  int    width [NCH] = '{35, 36, 35, 2, 34};

  logic        drv_v [NCH];
  logic [63:0] drv_d [NCH];
  logic        snk_r [NCH];
  logic        in_v [NCH], in_r [NCH], out_v [NCH], out_r [NCH];
  logic [63:0] in_d [NCH], out_d [NCH];

  logic [63:0] stim [NCH][$];
  logic [63:0] sb   [NCH][$];
  int          vpct [NCH], rpct [NCH];
  int          acc_in [NCH], acc_out [NCH], in_cyc [NCH], out_cyc [NCH];
  logic [63:0] last_out [NCH];
  int          r_cycles [$];
  int          cyc = 0;
  bit          rdy_ok = 1'b0;
  int          wr_cnt = 0, rd_cnt = 0;
  int          n_checks = 0, n_errors = 0;

  always_comb begin
    m_if.awvalid = drv_v[0];
    {m_if.awprot, m_if.awaddr} = drv_d[0][34:0];
    s_if.awready = snk_r[0];
    m_if.wvalid = drv_v[1];
    {m_if.wstrb, m_if.wdata} = drv_d[1][35:0];
    s_if.wready = snk_r[1];
    m_if.arvalid = drv_v[2];
    {m_if.arprot, m_if.araddr} = drv_d[2][34:0];
    s_if.arready = snk_r[2];
    s_if.bvalid = drv_v[3];
    s_if.bresp = drv_d[3][1:0];
    m_if.bready = snk_r[3];
    s_if.rvalid = drv_v[4];
    {s_if.rresp, s_if.rdata} = drv_d[4][33:0];
    m_if.rready = snk_r[4];
  end

  assign in_v[0] = m_if.awvalid;  assign in_r[0] = m_if.awready;
  assign in_v[1] = m_if.wvalid;   assign in_r[1] = m_if.wready;
  assign in_v[2] = m_if.arvalid;  assign in_r[2] = m_if.arready;
  assign in_v[3] = s_if.bvalid;   assign in_r[3] = s_if.bready;
  assign in_v[4] = s_if.rvalid;   assign in_r[4] = s_if.rready;
  assign in_d[0] = 64'({m_if.awprot, m_if.awaddr});
  assign in_d[1] = 64'({m_if.wstrb, m_if.wdata});
  assign in_d[2] = 64'({m_if.arprot, m_if.araddr});
  assign in_d[3] = 64'(s_if.bresp);
  assign in_d[4] = 64'({s_if.rresp, s_if.rdata});
  assign out_v[0] = s_if.awvalid; assign out_r[0] = s_if.awready;
  assign out_v[1] = s_if.wvalid;  assign out_r[1] = s_if.wready;
  assign out_v[2] = s_if.arvalid; assign out_r[2] = s_if.arready;
  assign out_v[3] = m_if.bvalid;  assign out_r[3] = m_if.bready;
  assign out_v[4] = m_if.rvalid;  assign out_r[4] = m_if.rready;
  assign out_d[0] = 64'({s_if.awprot, s_if.awaddr});
  assign out_d[1] = 64'({s_if.wstrb, s_if.wdata});
  assign out_d[2] = 64'({s_if.arprot, s_if.araddr});
  assign out_d[3] = 64'(m_if.bresp);
  assign out_d[4] = 64'({m_if.rresp, m_if.rdata});

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [63:0] rnd(input int ch);
    logic [63:0] m;
    m = (64'd1 << width[ch]) - 64'd1;
    return {$urandom, $urandom} & m;
  endfunction

  function automatic bit all_idle();
    for (int i = 0; i < NCH; i++)
      if (stim[i].size() != 0 || sb[i].size() != 0 || drv_v[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference: each channel is a FIFO of depth 2; an accepted beat is visible
  // on the far side from the next cycle; ready means "fewer than 2 held".
  always @(negedge clk) begin : monitor
    logic exp_r;
    bit   aw_hs, b_hs, ar_hs, r_hs;
    for (int i = 0; i < NCH; i++) begin
      exp_r = rdy_ok && (sb[i].size() < 2);
`ifdef UVMT_AXIL_ST_REG_SLICE_OUTSTANDING_LIMIT_EN
      if (i == 0) exp_r = exp_r && (wr_cnt != MAXO);
      if (i == 2) exp_r = exp_r && (rd_cnt != MAXO);
`endif
      chk({cname[i], "_in_ready"}, 64'(in_r[i]), 64'(exp_r));
      chk({cname[i], "_out_valid"}, 64'(out_v[i]), 64'(sb[i].size() != 0));
      if (sb[i].size() != 0) chk({cname[i], "_payload"}, out_d[i], sb[i][0]);
    end
    if (!reset_n) begin
      for (int i = 0; i < NCH; i++) sb[i].delete();
      rdy_ok = 1'b0;
      wr_cnt = 0;
      rd_cnt = 0;
    end else begin
      rdy_ok = 1'b1;
      aw_hs = in_v[0] && in_r[0];
      ar_hs = in_v[2] && in_r[2];
      b_hs  = out_v[3] && out_r[3];
      r_hs  = out_v[4] && out_r[4];
      for (int i = 0; i < NCH; i++) begin
        if (out_v[i] && out_r[i] && sb[i].size() != 0) begin
          void'(sb[i].pop_front());
          acc_out[i]++;
          out_cyc[i] = cyc;
          last_out[i] = out_d[i];
          if (i == 4) r_cycles.push_back(cyc);
        end
        if (in_v[i] && in_r[i]) begin
          sb[i].push_back(in_d[i]);
          acc_in[i]++;
          in_cyc[i] = cyc;
        end
      end
      if (aw_hs && !b_hs) wr_cnt++;
      else if (b_hs && !aw_hs && wr_cnt > 0) wr_cnt--;
      if (ar_hs && !r_hs) rd_cnt++;
      else if (r_hs && !ar_hs && rd_cnt > 0) rd_cnt--;
    end
  end

  // Driver: holds valid and payload until handshake, random gaps and readies.
  initial begin : driver
    bit hs [NCH];
    forever begin
      @(negedge clk);
      for (int i = 0; i < NCH; i++) hs[i] = drv_v[i] && in_r[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        if (hs[i] && stim[i].size() != 0) void'(stim[i].pop_front());
        if (stim[i].size() == 0) drv_v[i] = 1'b0;
        else if (!(drv_v[i] && !hs[i])) drv_v[i] = (int'($urandom_range(99)) < vpct[i]);
        drv_d[i] = (stim[i].size() != 0) ? stim[i][0] : 64'd0;
        snk_r[i] = (int'($urandom_range(99)) < rpct[i]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    bit idle;
    n = 0;
    idle = all_idle();
    while (n < budget && !idle) begin
`ifdef UVMT_AXIL_ST_REG_SLICE_OUTSTANDING_LIMIT_EN
      if (stim[0].size() != 0 && stim[3].size() == 0 && wr_cnt == MAXO) stim[3].push_back(64'd0);
      if (stim[2].size() != 0 && stim[4].size() == 0 && rd_cnt == MAXO) stim[4].push_back(rnd(4));
`endif
      step(1);
      n++;
      idle = all_idle();
    end
    chk({name, "_drained"}, 64'(idle), 64'd1);
  endtask

  initial begin : main
    int base_in, base_out, last;
    for (int i = 0; i < NCH; i++) begin
      drv_v[i] = 1'b0; drv_d[i] = 64'd0; snk_r[i] = 1'b0;
      vpct[i] = 100; rpct[i] = 100;
      acc_in[i] = 0; acc_out[i] = 0; in_cyc[i] = 0; out_cyc[i] = 0; last_out[i] = 64'd0;
    end
    reset_n = 1'b0;
    step(3);
    for (int i = 0; i < NCH; i++) begin
      chk({cname[i], "_ready_in_reset"}, 64'(in_r[i]), 64'd0);
      chk({cname[i], "_valid_in_reset"}, 64'(out_v[i]), 64'd0);
    end
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < NCH; i++) chk({cname[i], "_ready_after_reset"}, 64'(in_r[i]), 64'd1);

    // single write, then its response
    stim[0].push_back(64'h10);
    stim[1].push_back(64'hF_DEAD_BEEF);
    drain("wr_req", 50);
    stim[3].push_back(64'd0);
    drain("wr_resp", 50);
    chk("aw_latency", 64'(out_cyc[0] - in_cyc[0]), 64'd1);
    chk("w_latency", 64'(out_cyc[1] - in_cyc[1]), 64'd1);
    chk("b_latency", 64'(out_cyc[3] - in_cyc[3]), 64'd1);
    chk("aw_value", last_out[0], 64'h10);
    chk("w_value", last_out[1], 64'hF_DEAD_BEEF);
    chk("b_value", last_out[3], 64'd0);

    // AR back-pressure: only two fit
    rpct[2] = 0;
    base_in = acc_in[2];
    base_out = acc_out[2];
    for (int k = 0; k < 3; k++) stim[2].push_back(64'(32'h1000 + 32'(k) * 4));
    step(8);
    chk("ar_bp_accepted", 64'(acc_in[2] - base_in), 64'd2);
    chk("ar_bp_arready", 64'(in_r[2]), 64'd0);
    chk("ar_bp_none_out", 64'(acc_out[2] - base_out), 64'd0);
    rpct[2] = 100;
    drain("ar_bp", 100);
    chk("ar_bp_delivered", 64'(acc_out[2] - base_out), 64'd3);

    // streaming reads
    r_cycles.delete();
    for (int k = 0; k < 16; k++) begin
      stim[2].push_back(rnd(2));
      stim[4].push_back(rnd(4));
    end
    drain("stream", 200);
    chk("r_stream_beats_ge16", 64'(r_cycles.size() >= 16), 64'd1);
    last = (r_cycles.size() >= 16) ? r_cycles[15] : -1;
    chk("r_stream_span", 64'(last - ((r_cycles.size() != 0) ? r_cycles[0] : 0)), 64'd15);

    // reset with AW and R buffers full
    rpct[0] = 0;
    rpct[4] = 0;
    for (int k = 0; k < 3; k++) begin
      stim[0].push_back(rnd(0));
      stim[4].push_back(rnd(4));
    end
    step(8);
    chk("aw_full_ready", 64'(in_r[0]), 64'd0);
    chk("r_full_ready", 64'(in_r[4]), 64'd0);
    reset_n = 1'b0;
    step(1);
    for (int i = 0; i < NCH; i++) begin
      chk({cname[i], "_valid_mid_reset"}, 64'(out_v[i]), 64'd0);
      chk({cname[i], "_ready_mid_reset"}, 64'(in_r[i]), 64'd0);
    end
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < NCH; i++) chk({cname[i], "_ready_post_reset"}, 64'(in_r[i]), 64'd1);
    rpct[0] = 100;
    rpct[4] = 100;
    drain("post_reset", 200);

`ifdef UVMT_AXIL_ST_REG_SLICE_OUTSTANDING_LIMIT_EN
    while (wr_cnt > 0) begin
      stim[3].push_back(64'd0);
      drain("lim_prep", 50);
    end
    base_in = acc_in[0];
    for (int k = 0; k < 3; k++) stim[0].push_back(rnd(0));
    step(8);
    chk("lim_aw_accepted", 64'(acc_in[0] - base_in), 64'd2);
    chk("lim_awready", 64'(in_r[0]), 64'd0);
    stim[3].push_back(64'd0);
    step(6);
    chk("lim_aw_third", 64'(acc_in[0] - base_in), 64'd3);
    drain("lim", 200);
`endif

    // randomized traffic with varying valid/ready densities
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < NCH; i++) begin
        vpct[i] = int'($urandom_range(100, 30));
        rpct[i] = int'($urandom_range(100, 30));
        for (int k = 0; k < 50; k++) stim[i].push_back(rnd(i));
      end
      drain("random", 3000);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
